// File: rtl/sll_iter.sv
`default_nettype none
// ============================================================================
// Module      : sll_iter
// Description : Iterative 32-bit logical left shifter. A five-stage log shifter
//               (16/8/4/2/1) is applied one stage per clock, giving a fixed
//               latency independent of the shift amount.
// Revision    : 1.0 - initial release
// ============================================================================
module sll_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_operandA,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_STAGE = 3'd4;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_stage;
    logic [31:0] r_work;
    logic [4:0]  r_amt;
    logic [31:0] w_shifted;
    logic        w_accept;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_SHIFT;
            S_SHIFT: if (r_stage == c_LAST_STAGE) w_state_next = S_DONE;
            S_DONE:  w_state_next = w_accept ? S_SHIFT : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Stage k shifts by 2^(4-k) when amount bit (4-k) is set.
    always_comb begin
        w_shifted = r_work;
        case (r_stage)
            3'd0:    if (r_amt[4]) w_shifted = r_work << 16;
            3'd1:    if (r_amt[3]) w_shifted = r_work << 8;
            3'd2:    if (r_amt[2]) w_shifted = r_work << 4;
            3'd3:    if (r_amt[1]) w_shifted = r_work << 2;
            3'd4:    if (r_amt[0]) w_shifted = r_work << 1;
            default: w_shifted = r_work;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stage <= 3'd0;
            r_work  <= 32'h0000_0000;
            r_amt   <= 5'd0;
        end else if (w_accept) begin
            r_stage <= 3'd0;
            r_work  <= data_operandA;
            r_amt   <= ctrl_shiftamt;
        end else if (r_state == S_SHIFT) begin
            r_stage <= r_stage + 3'd1;
            r_work  <= w_shifted;
        end
    end

    assign result = r_work;
    assign busy   = (r_state == S_SHIFT);
    assign done   = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sll_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sll_iter
// Description : Directed self-checking bench for the iterative left shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sll_iter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    sll_iter dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .data_operandA (data_operandA),
        .ctrl_shiftamt (ctrl_shiftamt),
        .result        (result),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one request and checks the five busy cycles and the done cycle.
    task automatic run_op(input logic [31:0] a, input logic [4:0] s,
                          input logic [31:0] exp, input string tag);
        start         = 1'b1;
        data_operandA = a;
        ctrl_shiftamt = s;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " done-early"}, {31'd0, done}, 32'd0);
            tick();
        end
        chk({tag, " busy-at-done"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " result"}, result, exp);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        start         = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        ctrl_shiftamt = 5'd7;
        tick();
        tick();
        chk("reset result", result, 32'h0000_0000);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // Maximum shift, first request after reset
        run_op(32'h0000_0001, 5'd31, 32'h8000_0000, "shamt31");
        tick();
        chk("shamt31 done-pulse", {31'd0, done}, 32'd0);
        chk("shamt31 hold", result, 32'h8000_0000);

        run_op(32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, "zerofill");
        tick();
        run_op(32'h8000_0001, 5'd1, 32'h0000_0002, "discard");
        tick();
        run_op(32'h1234_5678, 5'd0, 32'h1234_5678, "shamt0");
        tick();
        run_op(32'hA5A5_A5A5, 5'd13, 32'hB4B4_A000, "shamt13");
        tick();

        // Start held high during busy is ignored
        start         = 1'b1;
        data_operandA = 32'h0000_000F;
        ctrl_shiftamt = 5'd4;
        tick();
        data_operandA = 32'hFFFF_FFFF;
        ctrl_shiftamt = 5'd1;
        for (int i = 0; i < 4; i++) begin
            chk("ignore busy", {31'd0, busy}, 32'd1);
            tick();
        end
        start = 1'b0;
        chk("ignore busy last", {31'd0, busy}, 32'd1);
        tick();
        chk("ignore done", {31'd0, done}, 32'd1);
        chk("ignore result", result, 32'h0000_00F0);
        tick();
        chk("ignore single-pulse", {31'd0, done}, 32'd0);
        chk("ignore idle busy", {31'd0, busy}, 32'd0);

        // Reset during stage 2
        start         = 1'b1;
        data_operandA = 32'h0000_00FF;
        ctrl_shiftamt = 5'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        chk("midreset result", result, 32'h0000_0000);
        run_op(32'h0000_0003, 5'd2, 32'h0000_000C, "postreset");

        // Back-to-back acceptance from the DONE cycle
        start         = 1'b1;
        data_operandA = 32'h0000_0001;
        ctrl_shiftamt = 5'd8;
        tick();
        start = 1'b0;
        chk("b2b busy", {31'd0, busy}, 32'd1);
        chk("b2b done-drop", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("b2b busy-last", {31'd0, busy}, 32'd1);
        tick();
        chk("b2b done", {31'd0, done}, 32'd1);
        chk("b2b result", result, 32'h0000_0100);
        tick();
        chk("b2b idle", {31'd0, done}, 32'd0);

        // Reset during DONE
        start         = 1'b1;
        data_operandA = 32'h0000_0005;
        ctrl_shiftamt = 5'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("donereset pre", result, 32'h0000_0028);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("donereset done", {31'd0, done}, 32'd0);
        chk("donereset busy", {31'd0, busy}, 32'd0);
        chk("donereset result", result, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
